// File: rtl/piso_serial_tx_pkg.sv
// Shared definitions for the framed serial links: FSM state encoding and gap counter sizing.
package piso_serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int GAP_CNT_W = 4;
  localparam int MAX_GAP   = 15;

endpackage

// File: rtl/piso_shift_core.sv
// Loadable WIDTH-bit shift register; zeros are shifted in so sout idles low once a word drains.
module piso_shift_core #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shifted = {shreg[WIDTH-2:0], 1'b0};
      assign sout    = shreg[WIDTH-1];
    end else begin : g_lsb_first
      assign shifted = {1'b0, shreg[WIDTH-1:1]};
      assign sout    = shreg[0];
    end
  endgenerate

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift_en) begin
      shreg <= shifted;
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Framed PISO transmitter: valid/ready intake, one-word holding slot, optional inter-frame gap.
module piso_serial_tx
  import piso_serial_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sframe,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic [WIDTH-1:0]       hold_word;
  logic                   hold_full;

  logic                   xfer;
  logic                   last_bit;
  logic                   gap_done;
  logic                   load;
  logic                   from_hold;
  logic                   shift_en;
  logic                   to_slot;
  logic [WIDTH-1:0]       load_data;

  assign din_ready = !hold_full;
  assign busy      = (state != IDLE) || hold_full;
  assign xfer      = din_valid && !hold_full;
  assign last_bit  = (state == SHIFT) && (bit_cnt == CNT_W'(WIDTH - 1));
  assign gap_done  = (state == GAP) && (gap_cnt == GAP_CNT_W'(GAP_CYCLES - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    load      = 1'b0;
    from_hold = 1'b0;
    shift_en  = 1'b0;
    unique case (state)
      IDLE: load = xfer;
      SHIFT: begin
        shift_en = 1'b1;
        if (last_bit && GAP_CYCLES == 0) begin
          from_hold = hold_full;
          load      = hold_full || xfer;
        end
      end
      GAP: begin
        if (gap_done) begin
          from_hold = hold_full;
          load      = hold_full || xfer;
        end
      end
      default: ;
    endcase
  end

  // An accepted word goes to the slot unless it is being launched straight into the shifter.
  assign to_slot   = xfer && !(load && !from_hold);
  assign load_data = from_hold ? hold_word : din;

  piso_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift_en(shift_en),
    .din     (load_data),
    .sout    (sout)
  );

  // NOTE: hold_word is reset too; it is one word wide, and a defined value keeps reset drops clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      hold_word <= '0;
      hold_full <= 1'b0;
      sframe    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= last_bit;

      if (from_hold) begin
        hold_full <= 1'b0;
      end else if (to_slot) begin
        hold_full <= 1'b1;
        hold_word <= din;
      end

      unique case (state)
        IDLE: begin
          if (load) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            sframe  <= 1'b1;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            bit_cnt <= bit_cnt + 1'b1;
          end else if (load) begin
            bit_cnt <= '0;
          end else if (GAP_CYCLES > 0) begin
            state   <= GAP;
            gap_cnt <= '0;
            sframe  <= 1'b0;
          end else begin
            state  <= IDLE;
            sframe <= 1'b0;
          end
        end
        GAP: begin
          if (!gap_done) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else if (load) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            sframe  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: three configurations share one stimulus stream and are checked
// every cycle against a frame-schedule model (accept time, launch time, payload per word).
module tb_piso_serial_tx;

  localparam int W  = 8;
  localparam int NI = 3;

  typedef struct {
    longint     a;
    longint     s;
    logic [7:0] d;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic          din_valid;
  logic [NI-1:0] din_ready, sout, sframe, busy, done;

  int     msb_cfg [NI];
  int     gap_cfg [NI];
  word_t  hist [NI][$];
  longint next_free [NI];
  longint cyc;
  int     tests;
  int     fails;
  logic [7:0] cap0, cap1;

  always #5 clk = ~clk;

  piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1), .GAP_CYCLES(1)) u_msb_gap1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[0]),
    .sout(sout[0]), .sframe(sframe[0]), .busy(busy[0]), .done(done[0])
  );

  piso_serial_tx #(.WIDTH(W), .MSB_FIRST(0), .GAP_CYCLES(1)) u_lsb_gap1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[1]),
    .sout(sout[1]), .sframe(sframe[1]), .busy(busy[1]), .done(done[1])
  );

  piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1), .GAP_CYCLES(0)) u_msb_gap0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[2]),
    .sout(sout[2]), .sframe(sframe[2]), .busy(busy[2]), .done(done[2])
  );

  task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
    end
  endtask

  // The slot is occupied from a word's accept edge until the edge its frame launches.
  function automatic logic ready_exp(int i, longint n);
    for (int k = 0; k < hist[i].size(); k++)
      if (hist[i][k].a <= n && n < hist[i][k].s) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_all(longint n);
    for (int i = 0; i < NI; i++) begin
      logic   e_sf, e_so, e_dn, e_bz, e_rd;
      longint off;
      e_sf = 0; e_so = 0; e_dn = 0; e_bz = 0; e_rd = 1;
      for (int k = 0; k < hist[i].size(); k++) begin
        word_t w;
        w = hist[i][k];
        if (n >= w.s && n < w.s + W) begin
          e_sf = 1;
          off  = n - w.s;
          e_so = (msb_cfg[i] != 0) ? w.d[W-1-off] : w.d[off];
        end
        if (n == w.s + W) e_dn = 1;
        if (n >= w.a && n < w.s + W + gap_cfg[i]) e_bz = 1;
        if (n >= w.a && n < w.s) e_rd = 0;
      end
      check("sframe", i, 32'(sframe[i]), 32'(e_sf));
      check("sout", i, 32'(sout[i]), 32'(e_so));
      check("done", i, 32'(done[i]), 32'(e_dn));
      check("busy", i, 32'(busy[i]), 32'(e_bz));
      check("din_ready", i, 32'(din_ready[i]), 32'(e_rd));
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        if (din_valid && ready_exp(i, cyc - 1)) begin
          word_t w;
          w.a = cyc;
          w.s = (next_free[i] > cyc) ? next_free[i] : cyc;
          w.d = din;
          hist[i].push_back(w);
          next_free[i] = w.s + W + gap_cfg[i];
        end
      end
    end
    @(negedge clk);
    check_all(cyc);
  endtask

  // Called between edges: reset must clear the outputs without waiting for a clock.
  task automatic async_reset();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      hist[i].delete();
      next_free[i] = 0;
    end
    #1;
    check_all(cyc);
  endtask

  initial begin
    msb_cfg = '{1, 0, 1};
    gap_cfg = '{1, 1, 0};
    tests = 0; fails = 0; cyc = 0;
    for (int i = 0; i < NI; i++) next_free[i] = 0;
    rst = 1'b0; din = '0; din_valid = 1'b0;

    // Reset held for two cycles, then released
    #2 check_all(cyc);
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();

    // Single word 8'hA5 on every configuration
    din = 8'hA5; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    cap0 = {7'b0, sout[0]};
    cap1 = {sout[1], 7'b0};
    for (int j = 1; j < W; j++) begin
      step();
      cap0 = {cap0[6:0], sout[0]};
      cap1 = {sout[1], cap1[7:1]};
    end
    check("frame_msb_a5", 0, 32'(cap0), 32'h0000_00A5);
    check("frame_lsb_a5", 1, 32'(cap1), 32'h0000_00A5);
    repeat (12) step();

    // Held valid: second word parks in the slot while the first drains
    din = 8'hA5; din_valid = 1'b1;
    step();
    din = 8'h3C;
    repeat (20) step();
    din_valid = 1'b0;
    repeat (24) step();

    // Back-to-back pair, streams continuously on the zero-gap instance
    din = 8'hF0; din_valid = 1'b1;
    step();
    din = 8'h0F;
    step();
    din_valid = 1'b0;
    repeat (22) step();

    // Asynchronous reset three bits into a frame, then a clean 8'hFF
    din = 8'hA5; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    repeat (2) step();
    #2 async_reset();
    repeat (2) step();
    rst = 1'b1;
    din = 8'hFF; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    cap0 = {7'b0, sout[0]};
    for (int j = 1; j < W; j++) begin
      step();
      cap0 = {cap0[6:0], sout[0]};
    end
    check("frame_after_reset", 0, 32'(cap0), 32'h0000_00FF);
    repeat (12) step();

    // Randomized traffic with occasional mid-cycle resets
    for (int r = 0; r < 600; r++) begin
      din       = 8'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      step();
      if ($urandom_range(0, 149) == 0) begin
        #2 async_reset();
        step();
        rst = 1'b1;
      end
    end
    din_valid = 1'b0;
    repeat (30) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
